// File: rtl/param_rf_sb.sv
`default_nettype none
// ============================================================================
// param_rf_sb : parameterised register file with lane write mask and a
//               per-register busy scoreboard (reserve / release-on-write).
//               Optional write-to-read forwarding under macro RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module param_rf_sb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LANES = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = WIDTH / LANES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    reg1,
    input  logic [AW-1:0]    reg2,
    input  logic [AW-1:0]    regw,
    input  logic [WIDTH-1:0] dataw,
    input  logic [LANES-1:0] wmask,
    input  logic             RFWrite,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_reg,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic             rdy1,
    output logic             rdy2,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      busy_cnt,
    output logic             rsv_err
);

    logic [WIDTH-1:0] rd_arr [DEPTH];
    logic [DEPTH-1:0] busy_next;
    logic [AW:0]      cnt_next;
    logic             rsv_conflict;

    // Each register owns its storage so every element has a single driver.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(i);
        logic [WIDTH-1:0] q;
        logic             we;

        assign we = RFWrite && (regw == IDX);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                q <= '0;
            end else if (we) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wmask[l]) begin
                        q[l*LW +: LW] <= dataw[l*LW +: LW];
                    end
                end
            end
        end

        assign rd_arr[i] = q;
    end

    // Release first, then reserve, so a same-register reserve wins.
    always_comb begin
        busy_next = busy;
        if (RFWrite) begin
            busy_next[regw] = 1'b0;
        end
        if (rsv_en) begin
            busy_next[rsv_reg] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    // A same-cycle release of the target register makes the re-reserve legal.
    assign rsv_conflict = rsv_en && busy[rsv_reg] && !(RFWrite && (regw == rsv_reg));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
            rsv_err  <= 1'b0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
            rsv_err  <= rsv_conflict;
        end
    end

`ifdef RF_BYPASS_EN
    function automatic logic [WIDTH-1:0] lane_merge(
        input logic [WIDTH-1:0] base,
        input logic [WIDTH-1:0] wd,
        input logic [LANES-1:0] m
    );
        logic [WIDTH-1:0] r;
        r = base;
        for (int l = 0; l < LANES; l++) begin
            if (m[l]) begin
                r[l*LW +: LW] = wd[l*LW +: LW];
            end
        end
        return r;
    endfunction

    logic hit1;
    logic hit2;

    assign hit1  = RFWrite && (regw == reg1);
    assign hit2  = RFWrite && (regw == reg2);
    assign data1 = hit1 ? lane_merge(rd_arr[reg1], dataw, wmask) : rd_arr[reg1];
    assign data2 = hit2 ? lane_merge(rd_arr[reg2], dataw, wmask) : rd_arr[reg2];
    assign rdy1  = hit1 | ~busy[reg1];
    assign rdy2  = hit2 | ~busy[reg2];
`else
    assign data1 = rd_arr[reg1];
    assign data2 = rd_arr[reg2];
    assign rdy1  = ~busy[reg1];
    assign rdy2  = ~busy[reg2];
`endif

endmodule
`default_nettype wire
